// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port video RAM between display fetch (strict priority) and the CPU bus
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   vid_req_i, vid_addr_i          single-cycle fetch strobe and address, no backpressure
//   vid_valid_o, vid_rdata_o       fetch data returned two cycles after vid_req_i
//   cpu_req_i, cpu_we_i,
//   cpu_addr_i, cpu_wdata_i        CPU request, held stable until cpu_ack_o
//   cpu_ack_o, cpu_rdata_o         one-cycle completion pulse, read data on read acks
//   mem_addr_o, mem_wdata_o,
//   mem_we_o, mem_re_o             registered RAM command
//   mem_rdata_i                    RAM read data, valid the cycle after mem_re_o
//   stat_clr_i, stall_cnt_o        clear and saturating count of CPU-denied cycles
module vram_arbiter #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int SWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              vid_req_i,
  input  logic [AWIDTH-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DWIDTH-1:0] vid_rdata_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [AWIDTH-1:0] cpu_addr_i,
  input  logic [DWIDTH-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DWIDTH-1:0] cpu_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  input  logic              stat_clr_i,
  output logic [SWIDTH-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {C_IDLE, C_WACK, C_RWAIT, C_RDATA} cstate_e;
  typedef enum logic [1:0] {T_NONE, T_VID, T_CPU} tag_e;
  cstate_e st_q, st_d;
  tag_e tag1_q, tag1_d, tag2_q;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic re_q, re_d, we_q, we_d;
  logic [SWIDTH-1:0] stall_q, stall_d;
  logic cpu_idle, cpu_gnt;
  always_comb begin
    cpu_idle = st_q == C_IDLE;
    // CPU only gets cycles video leaves free, and only once per request
    cpu_gnt  = !vid_req_i && cpu_idle && cpu_req_i;
    st_d     = C_IDLE;
    if (cpu_gnt) st_d = cpu_we_i ? C_WACK : C_RWAIT;
    else if (st_q == C_RWAIT) st_d = C_RDATA;
    re_d     = vid_req_i || (cpu_gnt && !cpu_we_i);
    we_d     = cpu_gnt && cpu_we_i;
    addr_d   = vid_req_i ? vid_addr_i : cpu_gnt ? cpu_addr_i : addr_q;
    wdata_d  = we_d ? cpu_wdata_i : wdata_q;
    // tag follows the read through the RAM's one-cycle latency to steer mem_rdata_i
    tag1_d   = vid_req_i ? T_VID : (cpu_gnt && !cpu_we_i) ? T_CPU : T_NONE;
    stall_d  = stat_clr_i ? '0 :
               (vid_req_i && cpu_req_i && cpu_idle && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q    <= C_IDLE;
      tag1_q  <= T_NONE;
      tag2_q  <= T_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      st_q    <= st_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag1_q;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      stall_q <= stall_d;
    end
  end
  assign vid_valid_o = tag2_q == T_VID;
  assign vid_rdata_o = vid_valid_o ? mem_rdata_i : '0;
  assign cpu_ack_o   = st_q == C_WACK || st_q == C_RDATA;
  assign cpu_rdata_o = tag2_q == T_CPU ? mem_rdata_i : '0;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign mem_re_o    = re_q;
  assign stall_cnt_o = stall_q;
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the display fetch engine and the CPU bus in the VGA/HDMI text/graphics systems. Display fetch has strict priority and a fixed, deadline-safe latency. CPU reads and writes are serviced in the remaining cycles through a req/ack handshake. A saturating stall counter reports how often the CPU is held off, so display timing budgets can be checked on hardware.

## Interface
- AWIDTH, default 16: word address width.
- DWIDTH, default 16: data width.
- SWIDTH, default 16: stall counter width.

- clk  in  1  system/pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- vid_req  in  1  single-cycle fetch strobe; no backpressure.
- vid_addr  in  AWIDTH  fetch address, sampled with vid_req.
- vid_valid  out  1  fetch data strobe.
- vid_rdata  out  DWIDTH  fetch data, qualified by vid_valid.
- cpu_req  in  1  CPU request; held high with addr/we/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AWIDTH  CPU address.
- cpu_wdata  in  DWIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DWIDTH  read data, qualified by cpu_ack on reads.
- mem_addr  out  AWIDTH  RAM address (registered).
- mem_wdata  out  DWIDTH  RAM write data (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_re  out  1  RAM read enable (registered).
- mem_rdata  in  DWIDTH  RAM read data, valid the cycle after mem_re.
- stat_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  SWIDTH  saturating count of CPU-denied cycles.

## Operation
- Arbitration each cycle N, on sampled inputs:
  - vid_req=1: issue the video read. Video always wins.
  - Otherwise, if the CPU FSM is in C_IDLE and cpu_req=1: issue the CPU access.
  - Otherwise: idle the memory (mem_re=mem_we=0; addr/wdata hold their last values).
- CPU FSM states:
  - C_IDLE: on grant, a write goes to C_WACK; a read goes to C_RWAIT.
  - C_WACK: cpu_ack=1, then C_IDLE.
  - C_RWAIT: wait one cycle, then C_RDATA.
  - C_RDATA: cpu_ack=1 and cpu_rdata=mem_rdata, then C_IDLE.
  - cpu_req is ignored in every state other than C_IDLE, so a held request is never issued twice.
- Read-source tag pipeline, 2 stages (NONE/VID/CPU), steers mem_rdata:
  - VID tag at stage 2 drives vid_valid=1 and vid_rdata=mem_rdata.
  - vid_rdata/cpu_rdata may show mem_rdata whenever their strobe is low; they are don't-care then.
- Stall counting:
  - stall_cnt increments in any cycle with cpu_req=1, FSM in C_IDLE, and vid_req=1.
  - It saturates at all-ones.
  - stat_clr has priority over increment; it zeroes the counter that cycle.
- Writes are posted: cpu_ack for a write means the RAM write has been issued, not that it is readable. A CPU read issued the next cycle returns the new data, because RAM ordering is preserved.

## Timing
- Reset value of every output is 0, including mem_addr, mem_wdata and stall_cnt. The FSM resets to C_IDLE and the tags to NONE.
- Reset mid-operation aborts any in-flight read; no vid_valid or cpu_ack is produced for it.
- Video latency:
  - vid_req in cycle N gives mem_re in N+1 and vid_valid in N+2.
  - Fixed and independent of CPU traffic.
  - Back-to-back vid_req every cycle is supported and returns back-to-back vid_valid.
- CPU write, granted in N:
  - mem_we=1 in N+1, and cpu_ack=1 in N+1.
  - A new cpu_req is sampled no earlier than N+2.
- CPU read, granted in N:
  - mem_re=1 in N+1.
  - cpu_ack=1 with cpu_rdata valid in N+2.
  - The next request is sampled no earlier than N+3.
- Simultaneous vid_req and cpu_req: video is issued. The CPU stays pending and is granted in the first cycle without vid_req.
- CPU wait is unbounded while vid_req is continuous; this is by design and is visible via stall_cnt.
- mem_re and mem_we are never both 1.

## Test plan
- Reset, then idle:
  - All outputs 0.
  - Assert reset asynchronously mid-read (CPU read of 0x0010 in flight); no cpu_ack ever appears for it.
- Video stream:
  - vid_req for 8 consecutive cycles, addr 0x0100..0x0107, RAM preloaded with data = addr ^ 0xA5A5.
  - 8 consecutive vid_valid starting 2 cycles after the first request, with matching data.
- CPU write then read:
  - Write 0x1234 to 0x0042; cpu_ack 1 cycle after grant.
  - Read 0x0042; cpu_ack 2 cycles after grant with cpu_rdata=0x1234.
- Contention:
  - cpu_req read 0x0001 held during a 5-cycle vid_req burst.
  - The CPU is granted the cycle after the burst ends.
  - stall_cnt=5.
  - Video latency is unchanged.
- Stall counter:
  - Force more than 2^SWIDTH contention cycles; stall_cnt sticks at 0xFFFF.
  - stat_clr coincident with a stall cycle gives 0 the next cycle.
- Randomized mix:
  - 10k cycles of random vid_req and CPU traffic against a reference RAM model.
  - Check every vid_rdata and cpu_rdata against the model.
  - Check no duplicate issue and mem_re and mem_we never both 1.
